// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 4 bytes
// between the 8-bit CPU data port and the word-organised data memory.
module dcache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t      state_q, state_d;
  logic        waited_q, waited_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  dirty_q, dirty_d;
  logic [2:0]  tag_q  [8];
  logic [2:0]  tag_d  [8];
  logic [31:0] data_q [8];
  logic [31:0] data_d [8];

  logic [2:0] addr_tag;
  logic [2:0] addr_index;
  logic [1:0] addr_offset;
  logic       request;
  logic       hit;
  logic       mem_done;

  assign addr_tag    = ADDRESS[7:5];
  assign addr_index  = ADDRESS[4:2];
  assign addr_offset = ADDRESS[1:0];
  assign request     = READ | WRITE;
  assign hit         = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  // Memory raises its busy at the first edge it sees a strobe, so an idle
  // busy only means completion once we have spent at least one edge in state.
  assign mem_done    = waited_q && !MEM_BUSYWAIT;

  assign BUSYWAIT = request && ((state_q != IDLE) || !hit);

  always_comb begin
    READDATA = 8'h00;
    if ((state_q == IDLE) && READ && !WRITE && hit) begin
      READDATA = data_q[addr_index][{addr_offset, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    waited_d      = 1'b0;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    tag_d         = tag_q;
    data_d        = data_q;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    case (state_q)
      IDLE: begin
        if (request) begin
          if (!hit) begin
            state_d = dirty_q[addr_index] ? WRITEBACK : FETCH;
          end else if (WRITE) begin
            data_d[addr_index][{addr_offset, 3'b000} +: 8] = WRITEDATA;
            dirty_d[addr_index] = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[addr_index], addr_index};
        MEM_WRITEDATA = data_q[addr_index];
        waited_d      = 1'b1;
        if (mem_done) begin
          state_d  = FETCH;
          waited_d = 1'b0;
        end
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_index};
        waited_d    = 1'b1;
        if (mem_done) begin
          data_d[addr_index]  = MEM_READDATA;
          tag_d[addr_index]   = addr_tag;
          valid_d[addr_index] = 1'b1;
          dirty_d[addr_index] = 1'b0;
          state_d             = IDLE;
          waited_d            = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      waited_q <= 1'b0;
      valid_q  <= 8'd0;
      dirty_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      waited_q <= waited_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
    end
  end

  // Tag and data arrays are deliberately left uninitialised by reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: behavioural memory with 5-cycle busy, a
// queue of expected memory transactions and a queue of expected load bytes.
module tb_dcache;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } memExp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'd0;
  logic [7:0]  WRITEDATA = 8'd0;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA = 32'd0;
  logic        MEM_BUSYWAIT;

  int total = 0;
  int bad = 0;

  memExp_t    memQ[$];
  logic [7:0] rdQ[$];

  logic [31:0] mem [64];
  bit          memInit = 1'b0;
  logic        memBusy = 1'b0;
  logic        memDone = 1'b0;
  int          memCnt = 0;
  logic        memIsWr = 1'b0;
  logic [5:0]  memAddr = 6'd0;
  logic [31:0] memWdata = 32'd0;
  logic [1:0]  memPrev = 2'b00;

  assign MEM_BUSYWAIT = memBusy;

  dcache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushMem(input logic wr, input logic [5:0] addr, input logic [31:0] data);
    memExp_t e;
    e.wr = wr;
    e.addr = addr;
    e.data = data;
    memQ.push_back(e);
  endtask

  // Every byte of the initial memory image equals its own byte address,
  // except block 0 which holds 0x44332211.
  always @(posedge CLK) begin
    if (!memInit) begin
      for (int i = 0; i < 64; i++) begin
        for (int b = 0; b < 4; b++) mem[i][8*b +: 8] <= 8'(i * 4 + b);
      end
      mem[0]  <= 32'h44332211;
      memInit <= 1'b1;
    end else if (RESET) begin
      memBusy <= 1'b0;
      memDone <= 1'b0;
      memCnt  <= 0;
    end else if (memBusy) begin
      if (memCnt == 1) begin
        memBusy <= 1'b0;
        memDone <= 1'b1;
        if (memIsWr) mem[memAddr] <= memWdata;
        else MEM_READDATA <= mem[memAddr];
      end
      memCnt <= memCnt - 1;
    end else if ((MEM_READ || MEM_WRITE) && !memDone) begin
      memBusy  <= 1'b1;
      memCnt   <= 5;
      memIsWr  <= MEM_WRITE;
      memAddr  <= MEM_ADDRESS;
      memWdata <= MEM_WRITEDATA;
    end else begin
      memDone <= 1'b0;
    end
  end

  // A new memory transaction shows up as a change in the strobe pair.
  always @(negedge CLK) begin
    logic [1:0] cur;
    memExp_t    e;
    cur = {MEM_WRITE, MEM_READ};
    if ((cur != 2'b00) && (cur != memPrev)) begin
      checkOutput("mem_strobes", {31'd0, cur == 2'b11}, 32'd0);
      if (memQ.size() == 0) begin
        checkOutput("mem_unexpected", {30'd0, cur}, 32'd0);
      end else begin
        e = memQ.pop_front();
        checkOutput("mem_op", {31'd0, MEM_WRITE}, {31'd0, e.wr});
        checkOutput("mem_addr", {26'd0, MEM_ADDRESS}, {26'd0, e.addr});
        if (e.wr) checkOutput("mem_wdata", MEM_WRITEDATA, e.data);
      end
    end
    memPrev <= cur;
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic [7:0] expData,
                               input logic expHit);
    int cycles;
    logic [7:0] e;
    @(negedge CLK);
    READ = rd;
    WRITE = wr;
    ADDRESS = addr;
    WRITEDATA = wdata;
    if (rd && !wr) rdQ.push_back(expData);
    #1;
    cycles = 0;
    while (BUSYWAIT && cycles < 100) begin
      @(negedge CLK);
      cycles++;
    end
    checkOutput("timeout", {31'd0, BUSYWAIT}, 32'd0);
    if (expHit) checkOutput("hit_stall", cycles, 0);
    else checkOutput("miss_stall", {31'd0, cycles > 0}, 32'd1);
    if (rd && !wr) begin
      e = rdQ.pop_front();
      checkOutput("readdata", {24'd0, READDATA}, {24'd0, e});
    end else begin
      checkOutput("readdata_on_write", {24'd0, READDATA}, 32'd0);
    end
    @(posedge CLK);
    #1;
    READ = 1'b0;
    WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    checkOutput("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    checkOutput("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    checkOutput("rst_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
    checkOutput("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
    checkOutput("rst_readdata", {24'd0, READDATA}, 32'd0);
    RESET = 1'b0;

    pushMem(1'b0, 6'h00, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h03, 8'h00, 8'h44, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h01, 8'hAB, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 8'hAB, 1'b1);

    pushMem(1'b1, 6'h00, 32'h4433AB11);
    pushMem(1'b0, 6'h08, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 8'h20, 1'b0);

    pushMem(1'b0, 6'h39, 32'd0);
    applyStimulus(1'b0, 1'b1, 8'hE6, 8'h5A, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hE6, 8'h00, 8'h5A, 1'b1);
    pushMem(1'b1, 6'h39, 32'hE75AE5E4);
    pushMem(1'b0, 6'h01, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h06, 8'h00, 8'h06, 1'b0);

    // Abort a fill with reset, then the same address must miss again.
    pushMem(1'b0, 6'h10, 32'd0);
    @(negedge CLK);
    READ = 1'b1;
    ADDRESS = 8'h40;
    for (int i = 0; i < 20 && !MEM_READ; i++) @(negedge CLK);
    checkOutput("abort_fetch_seen", {31'd0, MEM_READ}, 32'd1);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    READ = 1'b0;
    @(negedge CLK);
    checkOutput("abort_mem_read", {31'd0, MEM_READ}, 32'd0);
    checkOutput("abort_busywait", {31'd0, BUSYWAIT}, 32'd0);
    checkOutput("abort_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
    RESET = 1'b0;

    pushMem(1'b0, 6'h10, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h40, 8'h00, 8'h40, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h41, 8'h77, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h41, 8'h00, 8'h77, 1'b1);
    pushMem(1'b1, 6'h10, 32'h43427740);
    pushMem(1'b0, 6'h00, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 8'hAB, 1'b0);

    repeat (3) @(negedge CLK);
    checkOutput("idle_mem_read", {31'd0, MEM_READ}, 32'd0);
    checkOutput("mem_q_empty", memQ.size(), 0);
    checkOutput("rd_q_empty", rdQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
